// File: rtl/bus_master_arbiter.sv
// One-hot bus arbiter with tenure watchdog and per-master ban until the request drops.
// Define BUS_ARBITER_ROUND_ROBIN_EN for round-robin selection; the default is lowest-index-first.
module bus_master_arbiter #(
  parameter int unsigned width        = 4,
  parameter int unsigned timeout      = 256,
  parameter int unsigned counterWidth = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [width-1:0] request,
  output logic [width-1:0] grant,
  output logic             busy,
  output logic             timedOut
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [counterWidth-1:0] last_count = counterWidth'(timeout - 1);

  state_t                  state;
  logic [counterWidth-1:0] counter;
  logic [counterWidth-1:0] counter_next;
  logic [width-1:0]        banned;
  logic [width-1:0]        banned_next;
  logic [width-1:0]        grant_next;
  logic [width-1:0]        eligible;
  logic [width-1:0]        selection;
  logic                    timed_next;
  logic                    take;

  // The owner is never a candidate, so a watchdog revocation cannot re-grant it.
  assign eligible = request & ~banned & ~grant;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  localparam int unsigned pw = (width > 1) ? $clog2(width) : 1;

  logic [pw-1:0] pointer;
  logic [pw-1:0] pointer_next;
  logic [pw-1:0] sel_index;

  // Each candidate's distance from pointer+1 (mod width); the nearest wins.
  always_comb begin
    int unsigned best;
    int unsigned dist;
    selection = '0;
    sel_index = pointer;
    best      = width;
    dist      = 0;
    for (int unsigned i = 0; i < width; i++) begin
      dist = i + width - 1 - int'(pointer);
      if (dist >= width) dist = dist - width;
      if (eligible[i] && (dist < best)) begin
        best         = dist;
        selection    = '0;
        selection[i] = 1'b1;
        sel_index    = pw'(i);
      end
    end
  end

  always_comb begin
    pointer_next = pointer;
    if (take && (selection != '0)) pointer_next = sel_index;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pointer <= pw'(width - 1);
    else          pointer <= pointer_next;
  end
`else
  assign selection = eligible & (~eligible + width'(1));
`endif

  always_comb begin
    state = (grant == '0) ? IDLE : BUSY;
  end

  always_comb begin
    grant_next   = grant;
    counter_next = counter;
    banned_next  = banned & request;
    timed_next   = 1'b0;
    take         = 1'b0;
    unique case (state)
      IDLE: begin
        if (eligible != '0) begin
          take         = 1'b1;
          counter_next = '0;
        end
      end
      BUSY: begin
        if ((request & grant) == '0) begin
          take         = 1'b1;
          counter_next = '0;
        end else if (counter == last_count) begin
          banned_next  = banned_next | grant;
          timed_next   = 1'b1;
          take         = 1'b1;
          counter_next = '0;
        end else begin
          counter_next = counter + counterWidth'(1);
        end
      end
    endcase
    if (take) grant_next = selection;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant    <= '0;
      busy     <= 1'b0;
      timedOut <= 1'b0;
      counter  <= '0;
      banned   <= '0;
    end else begin
      grant    <= grant_next;
      busy     <= |grant_next;
      timedOut <= timed_next;
      counter  <= counter_next;
      banned   <= banned_next;
    end
  end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Bench for bus_master_arbiter (width=4, timeout=8): directed scenarios plus random requests
// checked against a tenure-level owner/ban model.
module tb_bus_master_arbiter;

  localparam int TIMEOUT = 8;

  logic       clk;
  logic       reset_n;
  logic [3:0] request;
  logic [3:0] grant;
  logic       busy;
  logic       timed_out;

  int checks;
  int errors;

  // Model: who owns the bus, how many cycles it has held it, who is banned.
  int     m_owner;
  int     m_held;
  int     m_ptr;
  bit [3:0] m_banned;
  bit     m_timed;

  bus_master_arbiter #(
    .width(4),
    .timeout(TIMEOUT),
    .counterWidth(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .request(request),
    .grant(grant),
    .busy(busy),
    .timedOut(timed_out)
  );

  always #5 clk = ~clk;

  function automatic int pick(input bit [3:0] c, input int ptr);
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (ptr + k) % 4;
      if (((c >> j) & 4'd1) != 4'd0) return j;
    end
`else
    for (int j = 0; j < 4; j++) begin
      if (((c >> j) & 4'd1) != 4'd0) return j;
    end
`endif
    return -1;
  endfunction

  function automatic logic [3:0] exp_grant();
    if (m_owner < 0) return 4'b0000;
    return 4'b0001 << m_owner;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_held   = 0;
    m_ptr    = 3;
    m_banned = 4'b0000;
    m_timed  = 0;
  endtask

  task automatic model_edge();
    bit [3:0] elig;
    bit [3:0] nb;
    bit       arb;
    int       nxt;
    elig = request & ~m_banned;
    if (m_owner >= 0) elig = elig & ~(4'b0001 << m_owner);
    nb      = m_banned & request;
    m_timed = 0;
    arb     = 0;
    if (m_owner < 0) begin
      arb = 1;
    end else if (((request >> m_owner) & 4'd1) == 4'd0) begin
      arb = 1;
    end else if (m_held == TIMEOUT) begin
      nb      = nb | (4'b0001 << m_owner);
      m_timed = 1;
      arb     = 1;
    end else begin
      m_held++;
    end
    if (arb) begin
      nxt = pick(elig, m_ptr);
      if (nxt >= 0 || m_owner >= 0) begin
        m_owner = nxt;
        m_held  = 1;
        if (nxt >= 0) m_ptr = nxt;
      end
    end
    m_banned = nb;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic test_reset();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL reset_timed: got %b expected 0", timed_out); end
    reset_n = 1;
    request = 4'b0010;
    step();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL reset_pre_grant: got %b expected 0010", grant); end
    step();
    reset_n = 0;
    model_reset();
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL async_reset_grant: got %b expected 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b expected 0", busy); end
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL async_reset_timed: got %b expected 0", timed_out); end
    request = 4'b0000;
    reset_n = 1;
    step();
    step();
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got grant %b busy %b expected 0000 0", grant, busy); end
  endtask

  task automatic test_grant();
    request = 4'b0110;
    step();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL grant_first: got %b expected 0010", grant); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL grant_busy: got %b expected 1", busy); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL grant_hold[%0d]: got %b expected 0010", i, grant); end
    end
  endtask

  task automatic test_handover();
    request = 4'b0100;
    step();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL handover_grant: got %b expected 0100", grant); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL handover_busy: got %b expected 1", busy); end
  endtask

  task automatic test_watchdog();
    request = 4'b0000;
    step();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL wd_idle: got %b expected 0000", grant); end
    request = 4'b0011;
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL wd_first: got %b expected 0001", grant); end
    for (int i = 1; i < TIMEOUT; i++) begin
      step();
      checks++; if (grant !== 4'b0001 || timed_out !== 1'b0) begin errors++; $display("FAIL wd_hold[%0d]: got grant %b timedOut %b expected 0001 0", i, grant, timed_out); end
    end
    step();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL wd_revoke_grant: got %b expected 0010", grant); end
    checks++; if (timed_out !== 1'b1) begin errors++; $display("FAIL wd_pulse: got %b expected 1", timed_out); end
    step();
    checks++; if (timed_out !== 1'b0 || grant !== 4'b0010) begin errors++; $display("FAIL wd_pulse_end: got timedOut %b grant %b expected 0 0010", timed_out, grant); end
    request = 4'b0001;
    step();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL wd_banned: got %b expected 0000", grant); end
    request = 4'b0000;
    step();
    request = 4'b0001;
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL wd_unbanned: got %b expected 0001", grant); end
  endtask

  task automatic test_boundary();
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL bnd_hold: got %b expected 0001", grant); end
    request = 4'b0100;
    step();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL bnd_release: got %b expected 0100", grant); end
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL bnd_no_pulse: got %b expected 0", timed_out); end
  endtask

  task automatic test_priority();
    logic [3:0] want;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    want = 4'b1000;
`else
    want = 4'b0001;
`endif
    request = 4'b1011;
    step();
    checks++; if (grant !== want) begin errors++; $display("FAIL priority: got %b expected %b", grant, want); end
    checks++; if (grant !== exp_grant()) begin errors++; $display("FAIL priority_model: got %b expected %b", grant, exp_grant()); end
  endtask

  task automatic test_random();
    logic [3:0] e;
    reset_n = 0;
    model_reset();
    #1;
    reset_n = 1;
    request = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) request[b] = ~request[b];
      end
      if (i == 300) begin
        reset_n = 0;
        model_reset();
        #1;
        checks++; if (grant !== 4'b0000 || busy !== 1'b0 || timed_out !== 1'b0) begin errors++; $display("FAIL rand_reset: got grant %b busy %b timedOut %b expected 0000 0 0", grant, busy, timed_out); end
        reset_n = 1;
      end
      step();
      e = exp_grant();
      checks++; if (grant !== e) begin errors++; $display("FAIL rand_grant[%0d]: got %b expected %b req %b", i, grant, e, request); end
      checks++; if (busy !== (e != 4'b0000)) begin errors++; $display("FAIL rand_busy[%0d]: got %b expected %b", i, busy, (e != 4'b0000)); end
      checks++; if (timed_out !== m_timed) begin errors++; $display("FAIL rand_timed[%0d]: got %b expected %b", i, timed_out, m_timed); end
      checks++; if ($countones(grant) > 1) begin errors++; $display("FAIL rand_onehot[%0d]: got %b expected at most one bit", i, grant); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL time_limit: simulation did not complete, got timeout expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    clk     = 1'b0;
    reset_n = 1'b0;
    request = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_grant();
    test_handover();
    test_watchdog();
    test_boundary();
    test_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_master_arbiter.md
# bus_master_arbiter

Registered bus arbiter that shares the single ECO32 system bus between `width` requesting masters (CPU fetch, CPU data, DMA, debug port). Grants are one-hot and held for the whole bus tenure, with a watchdog that forcibly revokes a master that holds the bus too long. Arbitration is lowest-index-first, or round-robin when the configuration macro is set. Sits between the masters' request lines and the bus multiplexer select.

## Interface

- `width`, default 4: number of masters; legal range 2..16.
- `timeout`, default 256: maximum consecutive cycles one master may hold a grant; legal range 1..2^`counterWidth`.
- `counterWidth`, default 8: width of the tenure counter.

- `clk`  input  1: system clock; all state updates on the rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `request`  input  `width`: per-master bus request; a master holds its bit high for its whole tenure.
- `grant`  output  `width`: registered one-hot or zero grant vector.
- `busy`  output  1: registered; high while any grant bit is high.
- `timedOut`  output  1: registered one-cycle pulse when a grant is revoked by the watchdog.

## Operation

- State: `grant` register, tenure counter, `banned[width-1:0]` mask, round-robin pointer (only with the macro).
- `eligible = request & ~banned`. During arbitration the current owner is also excluded from `eligible`.
- IDLE (`grant == 0`): on each edge, if `eligible != 0`, `grant` <= the selected bit and counter <= 0. Otherwise IDLE persists.
- BUSY (`grant != 0`), evaluated on each edge in priority order:
  - Release: `request[owner] == 0`. Immediate handover: `grant` <= selection from `eligible`, which may be 0. Counter <= 0. No dead cycle.
  - Watchdog: `request[owner] == 1` and counter == `timeout-1`. `banned[owner]` <= 1, `timedOut` <= 1, and `grant` <= selection from `eligible` with the owner excluded. Counter <= 0.
  - Otherwise: hold `grant`; counter += 1.
- If release and watchdog conditions coincide, release wins and there is no pulse.
- Ban clear: `banned[i]` <= 0 on any edge where `request[i] == 0`. A banned master must drop its request for at least one cycle before it can be granted again.
- Selection without the macro: lowest set bit of the candidate vector, using the same rule as the existing request/grant priority logic.
- Selection with the macro: scan starts at index `(pointer+1) mod width` and wraps. `pointer` <= index of each newly granted master.
- Counter arithmetic is unsigned, `counterWidth` bits. It is compared only against `timeout-1`, so it never wraps in normal operation.
- `busy = |grant`, taken from the registered value.

## Timing

- Reset (`reset_n` low, asynchronous): `grant` = 0, `busy` = 0, `timedOut` = 0, counter = 0, `banned` = 0, `pointer` = `width-1` so that index 0 has first priority. Outputs change immediately, without waiting for a clock edge.
- Reset release mid-tenure: no grant exists afterwards. Masters must re-arbitrate from IDLE.
- Grant latency: request high before edge N gives `grant` high after edge N (1 cycle).
- Release latency: request low before edge N gives `grant` low, or handed over, after edge N.
- Maximum tenure: exactly `timeout` cycles with the grant high. `timedOut` is high during the first cycle after revocation.
- `grant` never has more than one bit set. There is never a cycle in which two masters both see a grant.

## Configuration

- `BUS_ARBITER_ROUND_ROBIN_EN` defined: round-robin selection with `pointer`, as above.
- Undefined: fixed lowest-index priority; `pointer` logic is not compiled in.
- All other behaviour (holding, watchdog, ban, reset) is identical in both builds.

## Test plan

All tests use `width=4`, `timeout=8`.

- Reset: assert `reset_n`=0 mid-tenure with `grant`=0010 -> `grant`=0000, `busy`=0, `timedOut`=0 before the next edge. After release with `request`=0000 -> outputs stay 0.
- Grant: `request`=0110 from IDLE -> after one edge `grant`=0010, `busy`=1. Grant is held while bit 1 stays high (e.g. 5 cycles).
- Handover: owner 1 drops with `request`=0100 -> on the same edge `grant`=0100, with no zero cycle between grants.
- Watchdog: `request`=0011 held -> `grant`=0001 for exactly 8 cycles, then `grant`=0010 and `timedOut`=1 for one cycle. Master 0 is not regranted until `request[0]` has gone low for at least one cycle.
- Boundary: owner drops its request on the same edge the counter reaches 7 -> normal release, `timedOut` stays 0.
- Priority: owner 2 releases with `request`=1011 -> `grant`=0001 without the macro, and `grant`=1000 with `BUS_ARBITER_ROUND_ROBIN_EN`.
